uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter OVERSAMPLE, default 16, sets sample_tick pulses per bit period; even, >= 4.
REQ-002 Parameter PARITY_EN, default 1, selects whether a parity bit follows the data bits.
REQ-003 Parameter PARITY_ODD, default 0, selects odd (1) or even (0) parity checking.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 sample_tick  input  1  one-clk-wide pulse at OVERSAMPLE x baud rate.
REQ-007 rx_serial  input  1  asynchronous serial line; idle high.
REQ-008 data_out  output  8  last received byte, LSB first on the line.
REQ-009 data_valid  output  1  one-clk pulse marking a completed frame.
REQ-010 parity_error  output  1  parity mismatch flag for the last frame.
REQ-011 framing_error  output  1  stop bit sampled low in the last frame.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 rx_serial shall pass through a 2-flop synchronizer, reset to 1; all logic below uses the synchronized value rx_s.
REQ-014 States: IDLE, START, DATA, PARITY, STOP; tick_cnt, bit_cnt (3-bit) and a shift register advance only on clks where sample_tick=1, except IDLE entry to START.
REQ-015 IDLE: when rx_s=0 on any clk, go to START with tick_cnt=0 on the next clk.
REQ-016 START: on the sample_tick making tick_cnt reach OVERSAMPLE/2-1, sample rx_s; 1 -> IDLE (glitch, no outputs change); 0 -> DATA, tick_cnt=0, bit_cnt=0.
REQ-017 DATA: on the sample_tick making tick_cnt reach OVERSAMPLE-1, sample rx_s into bit position bit_cnt (LSB first), tick_cnt=0, bit_cnt+1 with 3-bit wrap.
REQ-018 After the sample with bit_cnt=7: go to PARITY if PARITY_EN=1, else STOP.
REQ-019 PARITY: sample at tick_cnt=OVERSAMPLE-1; mismatch = (XOR of 8 data bits XOR sampled bit) != PARITY_ODD; go to STOP.
REQ-020 STOP: sample at tick_cnt=OVERSAMPLE-1; on the next clk load data_out with the assembled byte, pulse data_valid for exactly one clk, update parity_error (0 if PARITY_EN=0) and framing_error (1 if stop sample was 0), and enter IDLE.
REQ-021 data_out, parity_error and framing_error shall hold their values until the next frame completes; a frame with errors still asserts data_valid.
REQ-022 A new start bit shall be accepted from IDLE on the clk following data_valid, so back-to-back frames with one stop bit are received without loss.
REQ-023 busy shall rise on the clk IDLE exits and fall on the clk IDLE is re-entered.
REQ-024 A sample_tick arriving while data_valid is being generated shall not advance tick_cnt for the next frame.
REQ-025 rx_serial changes between ticks shall have no effect except the IDLE start detection in REQ-015.

Reset
REQ-026 On rst_n=0, immediately: state=IDLE, tick_cnt=0, bit_cnt=0, shift register=0, synchronizer flops=1, data_out=8'h00, data_valid=0, parity_error=0, framing_error=0, busy=0.
REQ-027 Reset asserted mid-frame shall discard the partial frame; no data_valid pulse after release until a complete new frame is received.
REQ-028 After rst_n release with rx_serial low, the receiver shall treat it as a start edge (REQ-015) and resolve via REQ-016.

Verification
REQ-029 Frame 0xA5, even parity bit 0, stop 1, OVERSAMPLE=16 -> one data_valid pulse, data_out=8'hA5, parity_error=0, framing_error=0.
REQ-030 rx_serial low for 4 sample_ticks then high -> START returns to IDLE, no data_valid, busy pulses high then low, data_out unchanged.
REQ-031 Frame 0x3C with stop bit 0 -> data_valid, data_out=8'h3C, framing_error=1, parity_error=0.
REQ-032 Frame 0x01 with parity bit 0 (even mode) -> data_valid, data_out=8'h01, parity_error=1; next good frame 0x02 clears it to 0.
REQ-033 Back-to-back frames 0x00 then 0xFF, single stop bit -> two data_valid pulses, data_out 8'h00 then 8'hFF, no errors.
REQ-034 rst_n pulsed low during DATA bit 4 of frame 0x55 -> all outputs at reset values, no data_valid; following frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// Oversampled 8-bit UART receiver with optional parity and stop-bit checking.
// Bits are sampled mid-bit by counting sample_tick pulses from the detected start edge.
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_tick,
  input  logic       rx_serial,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_nx;
  logic            rx_meta, rx_s;
  logic [TW-1:0]   tick_cnt, tick_nx;
  logic [2:0]      bit_cnt, bit_nx;
  logic [7:0]      shift, shift_nx;
  logic            perr_q, perr_nx;
  logic            done;

  function automatic logic parity_mismatch(input logic [7:0] d, input logic pbit);
    return ((^d) ^ pbit) != PAR_ODD;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      perr_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      tick_cnt <= tick_nx;
      bit_cnt  <= bit_nx;
      shift    <= shift_nx;
      perr_q   <= perr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tick_nx  = tick_cnt;
    bit_nx   = bit_cnt;
    shift_nx = shift;
    perr_nx  = perr_q;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx = START;
          tick_nx  = '0;
        end
      end
      START: begin
        if (sample_tick) begin
          if (tick_cnt == HALF_M1) begin
            tick_nx = '0;
            bit_nx  = '0;
            // A high line at mid start bit means the falling edge was a glitch.
            state_nx = rx_s ? IDLE : DATA;
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (sample_tick) begin
          if (tick_cnt == FULL_M1) begin
            tick_nx  = '0;
            shift_nx = {rx_s, shift[7:1]};
            bit_nx   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state_nx = PAR_EN ? PARITY : STOP;
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (sample_tick) begin
          if (tick_cnt == FULL_M1) begin
            tick_nx  = '0;
            perr_nx  = parity_mismatch(shift, rx_s);
            state_nx = STOP;
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (sample_tick) begin
          if (tick_cnt == FULL_M1) begin
            tick_nx  = '0;
            done     = 1'b1;
            state_nx = IDLE;
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result registers are written on the stop-sample clock so they appear one clock later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out      <= 8'h00;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_valid <= done;
      if (done) begin
        data_out      <= shift;
        parity_error  <= PAR_EN & perr_q;
        framing_error <= ~rx_s;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames plus randomized frames,
// with expected results derived from the frame contents by plain arithmetic.
module tb_uart_receiver;

  localparam int OS  = 16;
  localparam int PEN = 1;
  localparam int POD = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_tick = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic prev_dv = 1'b0;
  int   div = 0;

  uart_receiver #(.OVERSAMPLE(OS), .PARITY_EN(PEN), .PARITY_ODD(POD)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx_serial(rx_serial),
    .data_out(data_out), .data_valid(data_valid), .parity_error(parity_error),
    .framing_error(framing_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // One tick every 4 clocks, updated on the falling edge so it is stable at rising edges.
  always @(negedge clk) begin
    div         <= (div == 3) ? 0 : div + 1;
    sample_tick <= (div == 3);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (sample_tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  function automatic logic good_parity(input logic [7:0] d);
    return logic'(($countones(d) % 2) != 0) ^ logic'(POD != 0);
  endfunction

  task automatic expect_frame(input logic [7:0] d, input logic pbit, input logic stopb);
    exp_t e;
    e.d  = d;
    e.pe = (PEN != 0) && (pbit != good_parity(d));
    e.fe = !stopb;
    q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb);
    expect_frame(d, pbit, stopb);
    rx_serial = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      wait_ticks(OS);
    end
    if (PEN != 0) begin
      rx_serial = pbit;
      wait_ticks(OS);
    end
    if (stopb) begin
      rx_serial = 1'b1;
      wait_ticks(OS);
    end else begin
      // Low through the mid-bit sample, then released so no false start follows.
      rx_serial = 1'b0;
      wait_ticks(10);
      rx_serial = 1'b1;
      wait_ticks(OS - 10);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"}, 32'(data_out), 32'h00);
    check({tag, "_data_valid"}, 32'(data_valid), 32'h0);
    check({tag, "_parity_error"}, 32'(parity_error), 32'h0);
    check({tag, "_framing_error"}, 32'(framing_error), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  // Monitor: every data_valid pops one expected frame.
  always @(negedge clk) begin
    prev_dv <= data_valid;
    if (rst_n && data_valid) begin
      exp_t e;
      check("dv_single_pulse", 32'(prev_dv), 32'h0);
      if (q.size() == 0) begin
        check("unexpected_valid_data", 32'(data_out), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        check("data_out", 32'(data_out), 32'(e.d));
        check("parity_error", 32'(parity_error), 32'(e.pe));
        check("framing_error", 32'(framing_error), 32'(e.fe));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       p, s;
    int         gap;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_ticks(4);

    send_frame(8'hA5, 1'b0, 1'b1);
    wait_ticks(OS);

    // Short low pulse: start bit rejected at mid-bit.
    rx_serial = 1'b0;
    wait_ticks(2);
    check("glitch_busy_high", 32'(busy), 32'h1);
    wait_ticks(2);
    rx_serial = 1'b1;
    wait_ticks(8);
    check("glitch_busy_low", 32'(busy), 32'h0);
    check("glitch_data_held", 32'(data_out), 32'hA5);
    wait_ticks(OS);

    send_frame(8'h3C, 1'b0, 1'b0);
    wait_ticks(OS);
    send_frame(8'h01, 1'b0, 1'b1);
    wait_ticks(2);
    check("perr_held", 32'(parity_error), 32'h1);
    wait_ticks(OS);
    send_frame(8'h02, 1'b1, 1'b1);
    wait_ticks(OS);

    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    wait_ticks(OS);
    check("idle_busy", 32'(busy), 32'h0);

    // Reset in the middle of data bit 4 of 0x55.
    d = 8'h55;
    rx_serial = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rx_serial = d[i];
      wait_ticks(OS);
    end
    rx_serial = d[4];
    wait_ticks(8);
    check("midframe_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rx_serial = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(3 * OS);
    check("post_reset_busy", 32'(busy), 32'h0);
    send_frame(8'h81, 1'b0, 1'b1);
    wait_ticks(OS);

    for (int k = 0; k < 30; k++) begin
      d   = 8'($urandom);
      p   = good_parity(d) ^ ($urandom_range(0, 3) == 0);
      s   = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, 2);
      if (!s && gap == 0) gap = 1;
      send_frame(d, p, s);
      if (gap > 0) wait_ticks(gap * OS);
    end

    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
